// File: rtl/ps2_pkg.sv
// Shared types and helpers for the device-side PS/2 transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT_HI,
    S_BIT_LO,
    S_GAP
  } state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned STOP_IDX   = 10;

  // Odd parity bit: data ones plus parity is always odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO queueing scancodes ahead of the PS/2 serialiser; flags are registered.
module ps2_tx_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic          do_wr, do_rd;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_wr   = wr && !full_q;
  assign do_rd   = rd && !empty_q;
  assign count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: pops queued bytes and drives 11-bit frames
// on ps2_clk/ps2_data, separated by an idle gap with both lines high.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV = 500,
  parameter int unsigned GAP     = 1000,
  parameter int unsigned AW      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [11:0] HALF_LOAD = 12'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP - 1);

  state_e                  state_q, state_d;
  logic [11:0]             half_q, half_d;
  logic [15:0]             gap_q, gap_d;
  logic [3:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    ps2_clk_q, ps2_clk_d;
  logic                    ps2_data_q, ps2_data_d;
  logic                    busy_q, busy_d;
  logic                    overflow_q, overflow_d;
  logic                    rd_c;
  logic [7:0]              fifo_dout;
  logic                    fifo_full, fifo_empty;

  ps2_tx_fifo #(.AW(AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .wr    (wr),
    .rd    (rd_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state; line outputs are derived from the next state so they register in step.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rd_c    = 1'b1;
          shift_d = {1'b1, odd_parity(fifo_dout), fifo_dout, 1'b0};
          bit_d   = '0;
          half_d  = HALF_LOAD;
          state_d = S_BIT_HI;
        end
      end
      S_BIT_HI: begin
        if (half_q == '0) begin
          half_d  = HALF_LOAD;
          state_d = S_BIT_LO;
        end else begin
          half_d = half_q - 12'd1;
        end
      end
      S_BIT_LO: begin
        if (half_q != '0) begin
          half_d = half_q - 12'd1;
        end else if (bit_q == 4'(STOP_IDX)) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          half_d  = HALF_LOAD;
          state_d = S_BIT_HI;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    ps2_clk_d  = (state_d != S_BIT_LO);
    ps2_data_d = (state_d == S_BIT_HI || state_d == S_BIT_LO) ? shift_d[0] : 1'b1;
    busy_d     = (state_d != S_IDLE);
    overflow_d = wr && fifo_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      half_q     <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign ps2_clk  = ps2_clk_q;
  assign ps2_data = ps2_data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: expected frames are queued on push and
// compared when the line monitor assembles a frame from ps2_clk falling edges.
module tb_ps2_kbd_tx;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned GAP      = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned DEF_DIV  = 500;
  localparam int unsigned DEF_GAP  = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       wr;
  logic       full, empty, busy, overflow, ps2_clk, ps2_data;
  logic [7:0] d_din;
  logic       d_wr;
  logic       d_full, d_empty, d_busy, d_overflow, d_ps2_clk, d_ps2_data;

  int checks = 0;
  int errors = 0;
  int falls  = 0;

  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .AW(AW)) u_dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .full(full), .empty(empty),
    .busy(busy), .overflow(overflow), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  ps2_kbd_tx u_dut_def (
    .clk(clk), .reset(reset), .din(d_din), .wr(d_wr), .full(d_full), .empty(d_empty),
    .busy(d_busy), .overflow(d_overflow), .ps2_clk(d_ps2_clk), .ps2_data(d_ps2_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    din = b;
    wr  = 1'b1;
    if (keep) exp_q.push_back(mk_frame(b));
    tick();
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while ((busy || !empty) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_in_time"}, 32'(n < bound), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Line monitor: sample data on each ps2_clk fall and time every low pulse.
  logic [10:0] rx;
  int          nbits   = 0;
  int          low_len = 0;
  logic        prev_clk = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      nbits    = 0;
      low_len  = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        falls++;
        rx[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          if (exp_q.size() == 0) check("frame_extra", 32'(exp_q.size()), 32'd1);
          else                   check("frame", 32'(rx), 32'(exp_q.pop_front()));
          nbits = 0;
        end
      end
      if (!ps2_clk) begin
        low_len++;
      end else if (!prev_clk) begin
        check("low_width", 32'(low_len), 32'(CLK_DIV));
        low_len = 0;
      end
      prev_clk = ps2_clk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    reset = 1'b1;
    wr    = 1'b0;
    din   = 8'h00;
    d_wr  = 1'b0;
    d_din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk",  32'(ps2_clk),  32'd1);
    check("rst_data", 32'(ps2_data), 32'd1);
    check("rst_busy", 32'(busy),     32'd0);
    check("rst_ovf",  32'(overflow), 32'd0);
    check("rst_empty",32'(empty),    32'd1);
    check("rst_full", 32'(full),     32'd0);
    reset = 1'b0;
    tick();

    // Single byte: start bit at cycle 2, busy falls at cycle 98.
    base = falls;
    push(8'h1C, 1'b1);
    wr = 1'b0;
    check("t1_c1_data", 32'(ps2_data), 32'd1);
    check("t1_c1_busy", 32'(busy),     32'd0);
    tick();
    check("t1_c2_data", 32'(ps2_data), 32'd0);
    check("t1_c2_busy", 32'(busy),     32'd1);
    check("t1_c2_clk",  32'(ps2_clk),  32'd1);
    n = 2;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("t1_busy_fall", 32'(n), 32'd98);
    check("t1_falls", 32'(falls - base), 32'd11);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Parity corner bytes.
    push(8'hF0, 1'b1); wr = 1'b0; wait_idle("par_f0", 300);
    push(8'h00, 1'b1); wr = 1'b0; wait_idle("par_00", 300);
    push(8'hFF, 1'b1); wr = 1'b0; wait_idle("par_ff", 300);
    push(8'h01, 1'b1); wr = 1'b0; wait_idle("par_01", 300);

    // Back-to-back: second start bit exactly one frame period after the first.
    push(8'hF0, 1'b1);
    push(8'h1C, 1'b1);
    wr = 1'b0;
    n = 2;
    while (n < 50) begin tick(); n++; end
    check("b2b_c50_empty", 32'(empty), 32'd0);
    while (n < 98) begin tick(); n++; end
    check("b2b_c98_data", 32'(ps2_data), 32'd1);
    check("b2b_c98_busy", 32'(busy),     32'd0);
    tick();
    check("b2b_c99_data",  32'(ps2_data), 32'd0);
    check("b2b_c99_busy",  32'(busy),     32'd1);
    check("b2b_c99_empty", 32'(empty),    32'd1);
    wait_idle("b2b", 300);

    // Overflow: ten pushes, the tenth finds the FIFO full and is dropped.
    for (int i = 0; i < 10; i++) begin
      check("ovf_full",  32'(full),     32'(i == 9));
      check("ovf_quiet", 32'(overflow), 32'd0);
      push(8'h30 + 8'(i), i < 9);
    end
    wr = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    wait_idle("ovf", 1200);

    // Reset during bit 5 with three bytes still queued.
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b1);
    wr = 1'b0;
    repeat (40) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst_mid_clk",   32'(ps2_clk),  32'd1);
    check("rst_mid_data",  32'(ps2_data), 32'd1);
    check("rst_mid_empty", 32'(empty),    32'd1);
    check("rst_mid_busy",  32'(busy),     32'd0);
    base = falls;
    repeat (200) tick();
    check("rst_mid_quiet", 32'(falls - base), 32'd0);
    push(8'hA5, 1'b1);
    wr = 1'b0;
    wait_idle("rst_recover", 300);

    // Default parameters on the second instance.
    d_din = 8'h5A;
    d_wr  = 1'b1;
    tick();
    d_wr = 1'b0;
    n = 1;
    while (d_ps2_clk && n < 1000) begin tick(); n++; end
    check("def_first_fall", 32'(n), 32'(2 + DEF_DIV));
    base = n;
    while (!d_ps2_clk && n < 2000) begin tick(); n++; end
    check("def_low_width", 32'(n - base), 32'(DEF_DIV));
    while (d_busy && n < 20000) begin tick(); n++; end
    check("def_busy_fall", 32'(n), 32'(2 + 22 * DEF_DIV + DEF_GAP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
